cdc_stream_hold_stage: RTL and testbench
========================================

Name: cdc_stream_hold_stage

Overview:
- Single-clock, two-entry registered stream stage placed directly downstream of the destination side of the clearable gray-code CDC FIFO.
- Consumes the FIFO's dst stream and presents an output whose valid and data never change until the output handshake completes. The FIFO may withdraw valid during a clear sequence; this stage shields downstream protocols from that.
- Also blocks intake while a clear is pending, counts completed transfers and flags the end of each clear sequence.

Parameters:
- WIDTH, 8, payload width in bits when T is not overridden.
- T, logic [WIDTH-1:0], payload type.
- CNT_WIDTH, 16, width of the transfer counter; must be >= 1.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- clear_pending_i  input  1  connected to dst_clear_pending_o of the FIFO; high for the whole clear sequence.
- flush_i  input  1  synchronous local abort; drops all buffered entries.
- in_data_i  input  T  upstream payload.
- in_valid_i  input  1  upstream valid; may fall without a handshake.
- in_ready_o  input/output: output  1  stage can accept.
- out_data_o  output  T  downstream payload.
- out_valid_o  output  1  downstream valid.
- out_ready_i  input  1  downstream ready.
- fill_o  output  2  number of occupied entries (0..2).
- xfer_cnt_o  output  CNT_WIDTH  saturating count of output handshakes.
- clear_done_o  output  1  one-cycle pulse when a clear sequence ends.

Behaviour:
- Storage: entry A drives out_data_o; entry B is the skid entry. State is EMPTY, ONE (A only) or TWO (A and B). fill_o is 0, 1 or 2 respectively.
- Reset (rst_i high, asynchronous): state EMPTY, out_valid_o=0, fill_o=0, xfer_cnt_o=0, clear_done_o=0, internal clear_pending delay flop=0. Data registers are not reset; out_data_o is don't-care while out_valid_o=0.
- Readiness: in_ready_o = (state != TWO) & !clear_pending_i & !flush_i.
  - It is combinational only from state and these two inputs.
  - There is no path from out_ready_i or in_valid_i.
- Output: out_valid_o = (state != EMPTY), driven from a register. There is no combinational path from any input to out_valid_o or out_data_o.
- Handshakes: in_hs = in_valid_i & in_ready_o; out_hs = out_valid_o & out_ready_i. An upstream withdrawal of valid without in_hs has no effect.
- Transitions when flush_i=0:
  - EMPTY: in_hs gives A<=in, next state ONE.
  - ONE, in_hs & !out_hs: B<=in, next state TWO.
  - ONE, out_hs & !in_hs: next state EMPTY.
  - ONE, in_hs & out_hs: A<=in, stay ONE.
  - ONE, neither: hold.
  - TWO, out_hs: A<=B, next state ONE. No intake is possible in TWO.
- Latency: a word accepted at cycle n into EMPTY is presented at cycle n+1. Throughput is 1 word/cycle sustained. Order is strictly FIFO.
- Stability: while out_valid_o=1 and out_ready_i=0, out_valid_o and out_data_o hold their values. This holds regardless of clear_pending_i or in_valid_i.
- clear_pending_i does not flush. Entries already captured are still delivered; only new intake is blocked.
- flush_i (synchronous, highest priority):
  - Next state EMPTY, even if out_hs occurs in the same cycle; a coincident out_hs still counts.
  - xfer_cnt_o <= 0 takes precedence over any increment.
  - This is the only case in which out_valid_o falls without a handshake.
- xfer_cnt_o: increments by 1 on out_hs and saturates at 2**CNT_WIDTH-1 (no wrap).
- clear_done_o: registered, equal to cp_q & !clear_pending_i, where cp_q is clear_pending_i delayed one cycle. It pulses one cycle after the falling edge of clear_pending_i, once per clear sequence.
- Reset mid-operation: all buffered words are lost and the outputs return to their reset values immediately (asynchronous).

Test Plan:
- Reset then stream: drive 0x11, 0x22, 0x33 on consecutive cycles with out_ready_i=1. Required: out_valid_o from cycle 1 to 3, data in order, fill_o stays 1, xfer_cnt_o=3.
- Backpressure: out_ready_i=0, send 0xA1 and 0xA2. Required: fill_o=2, in_ready_o=0, out_data_o=0xA1 held stable for 10 cycles. Then release out_ready_i: 0xA2 follows, fill_o returns to 0.
- Withdrawal: in_valid_i pulses high while in_ready_o=0, then falls. Required: no capture and fill_o unchanged.
- Clear sequence: with fill_o=2, hold clear_pending_i=1 for 6 cycles while out_ready_i=1. Required: in_ready_o=0 throughout, both words delivered, clear_done_o high exactly 1 cycle after the fall of clear_pending_i.
- Flush: with fill_o=2 and xfer_cnt_o=5, assert flush_i for one cycle. Required: next cycle fill_o=0, out_valid_o=0, xfer_cnt_o=0.
- Saturation: CNT_WIDTH=2, 5 transfers. Required: xfer_cnt_o = 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/cdc_stream_hold_stage.sv
`default_nettype none
// ============================================================================
// cdc_stream_hold_stage : two-entry stable-output stage behind the CDC FIFO
// Revision: 1.0
// ============================================================================
module cdc_stream_hold_stage #(
  parameter int  WIDTH     = 8,
  parameter type T         = logic [WIDTH-1:0],
  parameter int  CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_pending_i,
  input  logic                 flush_i,
  input  T                     in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output T                     out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [1:0]           fill_o,
  output logic [CNT_WIDTH-1:0] xfer_cnt_o,
  output logic                 clear_done_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  T                     a_q, a_d;
  T                     b_q, b_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 cp_q, cp_d;
  logic                 clear_done_q, clear_done_d;
  logic                 in_hs;
  logic                 out_hs;

  // Intake gating deliberately ignores in_valid_i/out_ready_i to keep paths short.
  assign in_ready_o = (state_q != S_TWO) & ~clear_pending_i & ~flush_i;
  assign in_hs      = in_valid_i & in_ready_o;
  assign out_hs     = valid_q & out_ready_i;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    cp_d         = clear_pending_i;
    clear_done_d = cp_q & ~clear_pending_i;

    case (state_q)
      S_EMPTY: begin
        if (in_hs) begin
          a_d     = in_data_i;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_hs && !out_hs) begin
          b_d     = in_data_i;
          state_d = S_TWO;
        end else if (out_hs && !in_hs) begin
          state_d = S_EMPTY;
        end else if (in_hs && out_hs) begin
          a_d = in_data_i;
        end
      end
      S_TWO: begin
        if (out_hs) begin
          a_d     = b_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    if (out_hs && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // Flush wins over everything, including a coincident output handshake.
    if (flush_i) begin
      state_d = S_EMPTY;
      cnt_d   = '0;
    end

    valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_EMPTY;
      valid_q      <= 1'b0;
      cnt_q        <= '0;
      cp_q         <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      cp_q         <= cp_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Payload registers carry no reset; they are only observed while valid.
  always_ff @(posedge clk_i) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign out_data_o   = a_q;
  assign out_valid_o  = valid_q;
  assign xfer_cnt_o   = cnt_q;
  assign clear_done_o = clear_done_q;
  assign fill_o       = (state_q == S_TWO) ? 2'd2 :
                        (state_q == S_ONE) ? 2'd1 : 2'd0;

endmodule
`default_nettype wire

// File: tb/tb_cdc_stream_hold_stage.sv
`default_nettype none
// ============================================================================
// tb_cdc_stream_hold_stage : scoreboard bench for the hold stage
// Revision: 1.0
// ============================================================================
module tb_cdc_stream_hold_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, clear_pending, flush, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, clear_done;
  logic [7:0]  out_data;
  logic [1:0]  fill;
  logic [15:0] xfer;

  logic        s_zero, s_rdy, s_valid;
  logic [7:0]  s_data;
  logic        s_in_ready, s_out_valid, s_done;
  logic [7:0]  s_out_data;
  logic [1:0]  s_fill;
  logic [1:0]  s_xfer;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  sb[$];

  cdc_stream_hold_stage #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .clear_pending_i(clear_pending), .flush_i(flush),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .fill_o(fill), .xfer_cnt_o(xfer), .clear_done_o(clear_done)
  );

  cdc_stream_hold_stage #(.WIDTH(8), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .clear_pending_i(s_zero), .flush_i(s_zero),
    .in_data_i(s_data), .in_valid_i(s_valid), .in_ready_o(s_in_ready),
    .out_data_o(s_out_data), .out_valid_o(s_out_valid), .out_ready_i(s_rdy),
    .fill_o(s_fill), .xfer_cnt_o(s_xfer), .clear_done_o(s_done)
  );

  // One clock of the main DUT: sample handshakes, update scoreboard, advance.
  task automatic cyc(output bit ohs, output logic [7:0] got, output logic [7:0] exp,
                     output bit rdy);
    bit ihs;
    #1;
    ihs = in_valid & in_ready;
    ohs = out_valid & out_ready;
    got = out_data;
    rdy = in_ready;
    exp = 8'hxx;
    if (ohs && sb.size() > 0) exp = sb.pop_front();
    if (ihs) sb.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear_pending = 0; flush = 0; in_valid = 0; in_data = 0; out_ready = 0;
    s_zero = 0; s_rdy = 1; s_valid = 0; s_data = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (fill !== 2'd0) begin bad++; $display("FAIL reset_fill got=%0d want=0", fill); end
    total++; if (xfer !== 16'd0) begin bad++; $display("FAIL reset_xfer got=%0d want=0", xfer); end
    total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL reset_cdone got=%b want=0", clear_done); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    logic [7:0] w [0:2] = '{8'h11, 8'h22, 8'h33};
    bit ohs, rdy; logic [7:0] got, exp; int pops = 0;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3);
      in_data  = (i < 3) ? w[i] : 8'h00;
      cyc(ohs, got, exp, rdy);
      if (ohs) begin
        pops++;
        total++; if (got !== exp) begin bad++; $display("FAIL stream_data got=%h want=%h", got, exp); end
      end
      total++; if (int'(fill) !== sb.size()) begin bad++; $display("FAIL stream_fill cyc=%0d got=%0d want=%0d", i, fill, sb.size()); end
      total++; if (out_valid !== (i < 3)) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b want=%b", i, out_valid, (i < 3)); end
    end
    in_valid = 0;
    total++; if (pops != 3) begin bad++; $display("FAIL stream_count got=%0d want=3", pops); end
    total++; if (xfer !== 16'd3) begin bad++; $display("FAIL stream_xfer got=%0d want=3", xfer); end
  endtask

  task automatic test_backpressure;
    bit ohs, rdy; logic [7:0] got, exp; int pops = 0;
    out_ready = 0;
    in_valid = 1; in_data = 8'hA1; cyc(ohs, got, exp, rdy);
    in_data = 8'hA2; cyc(ohs, got, exp, rdy);
    in_valid = 0;
    total++; if (fill !== 2'd2) begin bad++; $display("FAIL bp_fill got=%0d want=2", fill); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", in_ready); end
    for (int i = 0; i < 10; i++) begin
      cyc(ohs, got, exp, rdy);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'hA1) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/a1", i, out_valid, out_data);
      end
    end
    out_ready = 1;
    repeat (3) begin
      cyc(ohs, got, exp, rdy);
      if (ohs) begin
        pops++;
        total++; if (got !== exp) begin bad++; $display("FAIL bp_data got=%h want=%h", got, exp); end
      end
    end
    total++; if (pops != 2) begin bad++; $display("FAIL bp_count got=%0d want=2", pops); end
    total++; if (fill !== 2'd0) begin bad++; $display("FAIL bp_drain_fill got=%0d want=0", fill); end
    total++; if (xfer !== 16'd5) begin bad++; $display("FAIL bp_xfer got=%0d want=5", xfer); end
  endtask

  task automatic test_flush;
    bit ohs, rdy; logic [7:0] got, exp;
    out_ready = 0;
    in_valid = 1; in_data = 8'hF1; cyc(ohs, got, exp, rdy);
    in_data = 8'hF2; cyc(ohs, got, exp, rdy);
    in_valid = 0;
    total++; if (fill !== 2'd2 || xfer !== 16'd5) begin bad++; $display("FAIL flush_pre got=%0d/%0d want=2/5", fill, xfer); end
    flush = 1;
    cyc(ohs, got, exp, rdy);
    flush = 0;
    sb.delete();
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", rdy); end
    total++; if (fill !== 2'd0) begin bad++; $display("FAIL flush_fill got=%0d want=0", fill); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    total++; if (xfer !== 16'd0) begin bad++; $display("FAIL flush_xfer got=%0d want=0", xfer); end
  endtask

  task automatic test_withdrawal;
    bit ohs, rdy; logic [7:0] got, exp; int pops = 0;
    out_ready = 0;
    in_valid = 1; in_data = 8'hB1; cyc(ohs, got, exp, rdy);
    in_data = 8'hB2; cyc(ohs, got, exp, rdy);
    in_data = 8'hEE; cyc(ohs, got, exp, rdy);
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL wd_ready got=%b want=0", rdy); end
    in_valid = 0; cyc(ohs, got, exp, rdy);
    total++; if (fill !== 2'd2) begin bad++; $display("FAIL wd_fill got=%0d want=2", fill); end
    out_ready = 1;
    repeat (3) begin
      cyc(ohs, got, exp, rdy);
      if (ohs) begin
        pops++;
        total++; if (got !== exp) begin bad++; $display("FAIL wd_data got=%h want=%h", got, exp); end
      end
    end
    total++; if (pops != 2 || fill !== 2'd0) begin bad++; $display("FAIL wd_drain got=%0d/%0d want=2/0", pops, fill); end
  endtask

  task automatic test_clear;
    bit ohs, rdy; logic [7:0] got, exp; int pops = 0;
    out_ready = 0;
    in_valid = 1; in_data = 8'hC1; cyc(ohs, got, exp, rdy);
    in_data = 8'hC2; cyc(ohs, got, exp, rdy);
    clear_pending = 1; out_ready = 1; in_data = 8'hDD;
    for (int i = 0; i < 6; i++) begin
      cyc(ohs, got, exp, rdy);
      total++; if (rdy !== 1'b0) begin bad++; $display("FAIL clr_ready cyc=%0d got=%b want=0", i, rdy); end
      total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL clr_done_early cyc=%0d got=%b want=0", i, clear_done); end
      if (ohs) begin
        pops++;
        total++; if (got !== exp) begin bad++; $display("FAIL clr_data got=%h want=%h", got, exp); end
      end
    end
    total++; if (pops != 2) begin bad++; $display("FAIL clr_count got=%0d want=2", pops); end
    clear_pending = 0; in_valid = 0;
    cyc(ohs, got, exp, rdy);
    total++; if (clear_done !== 1'b1) begin bad++; $display("FAIL clr_done_pulse got=%b want=1", clear_done); end
    cyc(ohs, got, exp, rdy);
    total++; if (clear_done !== 1'b0) begin bad++; $display("FAIL clr_done_width got=%b want=0", clear_done); end
  endtask

  task automatic test_reset_mid;
    bit ohs, rdy; logic [7:0] got, exp;
    out_ready = 0;
    in_valid = 1; in_data = 8'h77; cyc(ohs, got, exp, rdy);
    in_valid = 0;
    total++; if (fill !== 2'd1 || xfer === 16'd0) begin bad++; $display("FAIL rstmid_pre got=%0d/%0d want=1/nonzero", fill, xfer); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || fill !== 2'd0 || xfer !== 16'd0) begin
      bad++; $display("FAIL rstmid_async got=%b/%0d/%0d want=0/0/0", out_valid, fill, xfer);
    end
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_saturation;
    bit ohs2; int k = 0; int want;
    for (int i = 0; i < 8; i++) begin
      s_valid = (i < 5);
      s_data  = 8'(i);
      #1 ohs2 = s_out_valid & s_rdy;
      @(posedge clk); #1;
      if (ohs2) begin
        k++;
        want = (k < 3) ? k : 3;
        total++; if (s_xfer !== 2'(want)) begin bad++; $display("FAIL sat_cnt xfer#%0d got=%0d want=%0d", k, s_xfer, want); end
      end
    end
    s_valid = 0;
    total++; if (k != 5) begin bad++; $display("FAIL sat_xfers got=%0d want=5", k); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_flush;
    test_withdrawal;
    test_clear;
    test_reset_mid;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
